// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared definitions for the UART receiver: receiver state
//            enumeration, default timing constants and a counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // 3.125 MHz system clock, 19200 baud
    localparam int c_clks_per_bit = 163;
    // dout_rdy window length in clk cycles
    localparam int c_rdy_cycles   = 163;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous input bit.
// Ports    : clk  - system clock
//            res  - asynchronous active-low reset
//            d    - asynchronous input
//            q    - synchronized output (two clk cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports    : clk       - system clock
//            res       - asynchronous active-low reset
//            rx        - asynchronous serial line, idle high
//            dout      - last correctly framed byte
//            dout_rdy  - byte-valid strobe, high for RDY_CYCLES cycles
//            frame_err - one-cycle pulse when the stop bit samples low
//            busy      - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_clks_per_bit,
    parameter int RDY_CYCLES   = c_rdy_cycles
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_rdy,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_cnt_w = cnt_width(CLKS_PER_BIT);
    localparam int c_rdy_w = cnt_width(RDY_CYCLES + 1);
    localparam int c_half  = (CLKS_PER_BIT - 1) / 2;

    // START lasts c_half cycles, so its last count is c_half-1
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'((c_half > 0) ? c_half - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_rdy_w-1:0] c_rdy_load  = c_rdy_w'(RDY_CYCLES);

    logic               w_rx_s;
    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic [7:0]         r_dout;
    logic [c_rdy_w-1:0] r_rdy_cnt;
    logic               r_frame_err;

    logic w_cnt_clr;
    logic w_cnt_run;
    logic w_bit_clr;
    logic w_sample_bit;
    logic w_stop_ok;
    logic w_stop_bad;
    logic w_half_done;
    logic w_bit_done;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .res (res),
        .d   (rx),
        .q   (w_rx_s)
    );

    assign w_half_done = (r_cnt == c_half_last);
    assign w_bit_done  = (r_cnt == c_bit_last);
    // The baud counter only advances while timing a bit; it is parked at 0
    // in IDLE and WAIT_HIGH so it can never wrap there.
    assign w_cnt_run   = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_bit_clr    = 1'b0;
        w_sample_bit = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (w_half_done) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        // start bit gone by mid-bit: treat as a glitch
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_bit_clr    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_clr    = 1'b1;
                    w_sample_bit = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // a line held low (break) must not start new frames
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_cnt <= '0;
            r_bit <= 3'd0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_bit_clr || (w_sample_bit && (r_bit == 3'd7))) begin
                r_bit <= 3'd0;
            end else if (w_sample_bit) begin
                r_bit <= r_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_shift     <= 8'h00;
            r_dout      <= 8'h00;
            r_rdy_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_sample_bit) begin
                r_shift[r_bit] <= w_rx_s;
            end
            if (w_stop_ok) begin
                r_dout <= r_shift;
            end
            // Window timer is independent of the FSM so a following frame
            // can be received while dout_rdy is still high.
            if (w_stop_ok) begin
                r_rdy_cnt <= c_rdy_load;
            end else if (r_rdy_cnt != '0) begin
                r_rdy_cnt <= r_rdy_cnt - 1'b1;
            end
            r_frame_err <= w_stop_bad;
        end
    end

    assign dout      = r_dout;
    assign dout_rdy  = (r_rdy_cnt != '0);
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule : uart_rx
`default_nettype wire
